// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port round-robin arbiter and access sequencer for a
// 64-byte big-endian data memory. Adds byte/halfword loads (zero-extended)
// and stores (sub-word stores done as read-modify-write), with range checks.
// Optional build macro: DMEM_ARB_STRICT_PRIO_EN (port 0 always wins ties).
module dmem_arbiter #(
    parameter int ADDR_W   = 6,
    parameter int DATA_W   = 32,
    parameter int MAX_ADDR = 60
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [1:0]        p0_size,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_gnt,
    output logic              p0_done,
    output logic [DATA_W-1:0] p0_rdata,
    output logic              p0_err,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [1:0]        p1_size,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_gnt,
    output logic              p1_done,
    output logic [DATA_W-1:0] p1_rdata,
    output logic              p1_err,
    output logic              busy,
    output logic              mem_wen,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, ACCESS, WRITE, DONE} state_t;

    localparam logic [1:0]        SZ_BYTE = 2'b00;
    localparam logic [1:0]        SZ_HALF = 2'b01;
    localparam logic [1:0]        SZ_WORD = 2'b10;
    localparam logic [1:0]        SZ_RSVD = 2'b11;
    localparam logic [ADDR_W-1:0] MAX_A   = ADDR_W'(MAX_ADDR);

    state_t              state_q, state_d;
    logic                last_q, last_d;
    logic                owner_q, owner_d;
    logic                we_q, we_d;
    logic [1:0]          size_q, size_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [23:0]         merge_q, merge_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                err_q, err_d;
    logic                pick1;

    // State and request-field registers; reset abandons any in-flight access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            owner_q <= 1'b0;
            we_q    <= 1'b0;
            size_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            merge_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            owner_q <= owner_d;
            we_q    <= we_d;
            size_q  <= size_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            merge_q <= merge_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Arbitration, access sequencing and memory-side outputs.
    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        owner_d   = owner_q;
        we_d      = we_q;
        size_d    = size_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        merge_d   = merge_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        pick1     = 1'b0;
        p0_gnt    = 1'b0;
        p1_gnt    = 1'b0;
        mem_wen   = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state_q)
            IDLE: begin
`ifdef DMEM_ARB_STRICT_PRIO_EN
                pick1 = p1_req && !p0_req;
`else
                pick1 = p1_req && (!p0_req || !last_q);
`endif
                if (p0_req || p1_req) begin
                    p0_gnt  = !pick1;
                    p1_gnt  = pick1;
                    owner_d = pick1;
                    last_d  = pick1;
                    we_d    = pick1 ? p1_we    : p0_we;
                    size_d  = pick1 ? p1_size  : p0_size;
                    addr_d  = pick1 ? p1_addr  : p0_addr;
                    wdata_d = pick1 ? p1_wdata : p0_wdata;
                    rdata_d = '0;
                    err_d   = 1'b0;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                mem_addr = addr_q;
                if (addr_q > MAX_A || size_q == SZ_RSVD) begin
                    rdata_d = '1;
                    err_d   = 1'b1;
                    state_d = DONE;
                end else if (!we_q) begin
                    case (size_q)
                        SZ_BYTE: rdata_d = {24'b0, mem_rdata[31:24]};
                        SZ_HALF: rdata_d = {16'b0, mem_rdata[31:16]};
                        default: rdata_d = mem_rdata;
                    endcase
                    state_d = DONE;
                end else if (size_q == SZ_WORD) begin
                    mem_wen   = 1'b1;
                    mem_wdata = wdata_q;
                    state_d   = DONE;
                end else begin
                    // Big-endian: the bytes kept by a sub-word store are the low ones.
                    merge_d = mem_rdata[23:0];
                    state_d = WRITE;
                end
            end
            WRITE: begin
                mem_wen  = 1'b1;
                mem_addr = addr_q;
                if (size_q == SZ_BYTE) begin
                    mem_wdata = {wdata_q[7:0], merge_q[23:0]};
                end else begin
                    mem_wdata = {wdata_q[15:0], merge_q[15:0]};
                end
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Completion outputs are gated so rdata/err read as zero outside done.
    always_comb begin
        busy     = (state_q != IDLE);
        p0_done  = (state_q == DONE) && !owner_q;
        p1_done  = (state_q == DONE) && owner_q;
        p0_rdata = p0_done ? rdata_q : '0;
        p1_rdata = p1_done ? rdata_q : '0;
        p0_err   = p0_done && err_q;
        p1_err   = p1_done && err_q;
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: table-driven + scoreboard bench for dmem_arbiter with a
// behavioural 64-byte big-endian memory.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        p0_req, p0_we, p1_req, p1_we;
    logic [1:0]  p0_size, p1_size;
    logic [5:0]  p0_addr, p1_addr;
    logic [31:0] p0_wdata, p1_wdata;
    logic        p0_gnt, p0_done, p0_err, p1_gnt, p1_done, p1_err;
    logic [31:0] p0_rdata, p1_rdata;
    logic        busy, mem_wen;
    logic [5:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata;

    logic [7:0]  mem [64];
    int          cyc;
    int          pass_cnt;
    int          total_cnt;

    typedef struct {
        bit          port;
        bit          we;
        logic [1:0]  size;
        logic [5:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        bit          exp_err;
        int          lat;
        int          wen;
        logic [31:0] exp_mwdata;
    } vec_t;

    typedef struct {
        bit          port;
        logic [31:0] rdata;
        bit          err;
        int          lat;
        int          wen;
        logic [31:0] mwdata;
        logic [5:0]  addr;
        int          gcyc;
    } sb_t;

    sb_t sbq[$];

    int          wen_cnt;
    int          wen_cyc;
    logic [31:0] wen_data;
    logic [5:0]  wen_addr;

    dmem_arbiter #(.ADDR_W(6), .DATA_W(32), .MAX_ADDR(60)) dut (
        .clk(clk), .rst_n(rst_n),
        .p0_req(p0_req), .p0_we(p0_we), .p0_size(p0_size), .p0_addr(p0_addr),
        .p0_wdata(p0_wdata), .p0_gnt(p0_gnt), .p0_done(p0_done),
        .p0_rdata(p0_rdata), .p0_err(p0_err),
        .p1_req(p1_req), .p1_we(p1_we), .p1_size(p1_size), .p1_addr(p1_addr),
        .p1_wdata(p1_wdata), .p1_gnt(p1_gnt), .p1_done(p1_done),
        .p1_rdata(p1_rdata), .p1_err(p1_err),
        .busy(busy), .mem_wen(mem_wen), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Cycle counter used for latency measurement.
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural memory: combinational big-endian read, clocked write.
    assign mem_rdata = {mem[mem_addr], mem[mem_addr + 6'd1],
                        mem[mem_addr + 6'd2], mem[mem_addr + 6'd3]};
    always @(posedge clk) begin
        if (mem_wen) begin
            mem[mem_addr]        <= mem_wdata[31:24];
            mem[mem_addr + 6'd1] <= mem_wdata[23:16];
            mem[mem_addr + 6'd2] <= mem_wdata[15:8];
            mem[mem_addr + 6'd3] <= mem_wdata[7:0];
        end
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    task automatic drive(input bit port, input bit req, input bit we, input logic [1:0] size,
                         input logic [5:0] addr, input logic [31:0] wdata);
        if (port) begin
            p1_req = req; p1_we = we; p1_size = size; p1_addr = addr; p1_wdata = wdata;
        end else begin
            p0_req = req; p0_we = we; p0_size = size; p0_addr = addr; p0_wdata = wdata;
        end
    endtask

    task automatic push_exp(input bit port, input logic [31:0] rdata, input bit err, input int lat,
                            input int wen, input logic [31:0] mwdata, input logic [5:0] addr);
        sb_t e;
        e.port = port; e.rdata = rdata; e.err = err; e.lat = lat;
        e.wen = wen; e.mwdata = mwdata; e.addr = addr; e.gcyc = cyc;
        sbq.push_back(e);
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 30 && sbq.size() != 0; i++) @(posedge clk);
        if (sbq.size() != 0) begin
            check(name, 64'(sbq.size()), 64'd0);
            sbq.delete();
        end
    endtask

    // Scoreboard monitor: counts memory writes per transaction, compares on done.
    always @(negedge clk) begin
        sb_t e;
        if (!rst_n) begin
            wen_cnt = 0;
        end else begin
            if (mem_wen) begin
                wen_cnt++;
                wen_cyc  = cyc;
                wen_data = mem_wdata;
                wen_addr = mem_addr;
            end
            if (!p0_done) check("p0_idle_outs", {31'b0, p0_err, p0_rdata}, 64'd0);
            if (!p1_done) check("p1_idle_outs", {31'b0, p1_err, p1_rdata}, 64'd0);
            if (p0_done || p1_done) begin
                check("done_onehot", 64'(p0_done & p1_done), 64'd0);
                if (sbq.size() == 0) begin
                    check("unexpected_done", 64'd1, 64'd0);
                end else begin
                    e = sbq.pop_front();
                    check("done_port", 64'(p1_done), 64'(e.port));
                    check("rdata", e.port ? 64'(p1_rdata) : 64'(p0_rdata), 64'(e.rdata));
                    check("err", e.port ? 64'(p1_err) : 64'(p0_err), 64'(e.err));
                    check("latency", 64'(cyc - e.gcyc), 64'(e.lat));
                    check("wen_count", 64'(wen_cnt), 64'(e.wen));
                    if (e.wen != 0) begin
                        check("mem_wdata", 64'(wen_data), 64'(e.mwdata));
                        check("mem_addr", 64'(wen_addr), 64'(e.addr));
                        check("wen_cycle", 64'(wen_cyc - e.gcyc), 64'(e.lat - 1));
                    end
                end
                wen_cnt = 0;
            end
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_gnt", {62'b0, p0_gnt, p1_gnt}, 64'd0);
        check("rst_done_err", {60'b0, p0_done, p1_done, p0_err, p1_err}, 64'd0);
        check("rst_rdata", {p0_rdata, p1_rdata}, 64'd0);
        check("rst_mem", {25'b0, mem_wen, mem_addr, mem_wdata}, 64'd0);
        rst_n = 1'b1;
    endtask

    task automatic run_vec(input vec_t v);
        bit got;
        got = 1'b0;
        @(negedge clk);
        drive(v.port, 1'b1, v.we, v.size, v.addr, v.wdata);
        for (int i = 0; i < 20; i++) begin
            #1;
            if (v.port ? p1_gnt : p0_gnt) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!got) begin
            check("gnt_timeout", 64'd0, 64'd1);
            drive(v.port, 1'b0, 1'b0, 2'b00, 6'd0, 32'd0);
            return;
        end
        push_exp(v.port, v.exp_rdata, v.exp_err, v.lat, v.wen, v.exp_mwdata, v.addr);
        @(posedge clk);
        #1 drive(v.port, 1'b0, 1'b0, 2'b00, 6'd0, 32'd0);
        wait_drain("done_timeout");
    endtask

    vec_t tbl[14];
    vec_t post;
    bit   exp_order[5];
    int   ng;
    bit   gp;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 8'(i * 17);
        mem[0] = 8'h99; mem[1] = 8'h36; mem[2] = 8'h8F; mem[3] = 8'h7E;
        mem[4] = 8'hD9; mem[5] = 8'hF6; mem[6] = 8'h4C; mem[7] = 8'h21;
        drive(1'b0, 1'b0, 1'b0, 2'b00, 6'd0, 32'd0);
        drive(1'b1, 1'b0, 1'b0, 2'b00, 6'd0, 32'd0);
        wen_cnt = 0;

        //           port we size   addr   wdata         rdata         err lat wen mwdata
        tbl[0]  = '{1'b0, 1'b0, 2'b10, 6'd0,  32'h0,        32'h99368F7E, 1'b0, 2, 0, 32'h0};
        tbl[1]  = '{1'b1, 1'b0, 2'b00, 6'd1,  32'h0,        32'h00000036, 1'b0, 2, 0, 32'h0};
        tbl[2]  = '{1'b1, 1'b0, 2'b01, 6'd2,  32'h0,        32'h00008F7E, 1'b0, 2, 0, 32'h0};
        tbl[3]  = '{1'b1, 1'b1, 2'b01, 6'd2,  32'h00001234, 32'h0,        1'b0, 3, 1, 32'h1234D9F6};
        tbl[4]  = '{1'b0, 1'b0, 2'b10, 6'd0,  32'h0,        32'h99361234, 1'b0, 2, 0, 32'h0};
        tbl[5]  = '{1'b0, 1'b1, 2'b10, 6'd61, 32'hDEADBEEF, 32'hFFFFFFFF, 1'b1, 2, 0, 32'h0};
        tbl[6]  = '{1'b0, 1'b1, 2'b11, 6'd0,  32'hDEADBEEF, 32'hFFFFFFFF, 1'b1, 2, 0, 32'h0};
        tbl[7]  = '{1'b1, 1'b0, 2'b10, 6'd60, 32'h0,        32'hFC0D1E2F, 1'b0, 2, 0, 32'h0};
        tbl[8]  = '{1'b0, 1'b0, 2'b00, 6'd63, 32'h0,        32'hFFFFFFFF, 1'b1, 2, 0, 32'h0};
        tbl[9]  = '{1'b1, 1'b1, 2'b00, 6'd60, 32'h000000A5, 32'h0,        1'b0, 3, 1, 32'hA50D1E2F};
        tbl[10] = '{1'b0, 1'b0, 2'b10, 6'd60, 32'h0,        32'hA50D1E2F, 1'b0, 2, 0, 32'h0};
        tbl[11] = '{1'b0, 1'b1, 2'b10, 6'd8,  32'hCAFEF00D, 32'h0,        1'b0, 2, 1, 32'hCAFEF00D};
        tbl[12] = '{1'b1, 1'b0, 2'b01, 6'd9,  32'h0,        32'h0000FEF0, 1'b0, 2, 0, 32'h0};
        tbl[13] = '{1'b0, 1'b0, 2'b10, 6'd1,  32'h0,        32'h361234D9, 1'b0, 2, 0, 32'h0};

        do_reset();
        for (int i = 0; i < 14; i++) run_vec(tbl[i]);

        // Reset asserted during the WRITE cycle of a byte store at addr 8.
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b1, 2'b00, 6'd8, 32'h00000077);
        #1 check("mw_gnt", 64'(p1_gnt), 64'd1);
        @(posedge clk);
        #1 drive(1'b1, 1'b0, 1'b0, 2'b00, 6'd0, 32'd0);
        @(posedge clk);
        #1 check("mw_wen_in_write", {62'b0, mem_wen, busy}, 64'd3);
        #1 rst_n = 1'b0;
        #1 check("mw_rst_immediate", {61'b0, mem_wen, busy, p1_done}, 64'd0);
        repeat (2) begin
            @(negedge clk);
            check("mw_no_done", 64'(p1_done), 64'd0);
        end
        rst_n = 1'b1;
        post = '{1'b0, 1'b0, 2'b10, 6'd8, 32'h0, 32'hCAFEF00D, 1'b0, 2, 0, 32'h0};
        run_vec(post);

        // Both ports requesting continuously from reset.
        do_reset();
`ifdef DMEM_ARB_STRICT_PRIO_EN
        exp_order = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
`else
        exp_order = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
`endif
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b0, 2'b10, 6'd0, 32'd0);
        drive(1'b1, 1'b1, 1'b0, 2'b10, 6'd4, 32'd0);
        ng = 0;
        for (int i = 0; i < 60 && ng < 5; i++) begin
            #1;
            if (p0_gnt || p1_gnt) begin
                gp = p1_gnt;
                check("arb_order", 64'(gp), 64'(exp_order[ng]));
                push_exp(gp, gp ? 32'hD9F64C21 : 32'h99361234, 1'b0, 2, 0, 32'h0, 6'd0);
                ng++;
                if (ng == 4) begin
                    @(posedge clk);
                    #1 drive(1'b0, 1'b0, 1'b0, 2'b00, 6'd0, 32'd0);
                end else if (ng == 5) begin
                    @(posedge clk);
                    #1 drive(1'b1, 1'b0, 1'b0, 2'b00, 6'd0, 32'd0);
                end
            end
            @(negedge clk);
        end
        if (ng < 5) check("arb_timeout", 64'(ng), 64'd5);
        drive(1'b0, 1'b0, 1'b0, 2'b00, 6'd0, 32'd0);
        drive(1'b1, 1'b0, 1'b0, 2'b00, 6'd0, 32'd0);
        wait_drain("arb_done_timeout");

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
